mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one unified memory port between the pipeline's instruction fetch (imem) and data access (dmem) requesters. It captures single-cycle request pulses from either side and issues them one at a time to memory. It routes each completion back to the requester that owns it. It sits between the pipeline's imem/dmem interfaces and the memory model, and its imem_resp/dmem_resp feed the pipeline freeze logic.

## Interface
- DMEM_PRIORITY, 1, 1: dmem wins simultaneous pending requests; 0: imem wins
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- imem_addr  in  32  fetch address, word aligned
- imem_rmask  in  4  nonzero for one cycle = fetch request
- imem_rdata  out  32  fetch data, valid with imem_resp
- imem_resp  out  1  fetch completion, one-cycle pulse
- dmem_addr  in  32  data address
- dmem_rmask  in  4  nonzero for one cycle = load request
- dmem_wmask  in  4  nonzero for one cycle = store request
- dmem_wdata  in  32  store data
- dmem_rdata  out  32  load data, valid with dmem_resp
- dmem_resp  out  1  load/store completion, one-cycle pulse
- mem_addr  out  32  registered
- mem_rmask  out  4  registered, one-cycle pulse per issued read
- mem_wmask  out  4  registered, one-cycle pulse per issued write
- mem_wdata  out  32  registered
- mem_rdata  in  32  memory read data
- mem_resp  in  1  memory completion, one-cycle pulse

## Operation
- A request is a cycle in which the side's mask (rmask | wmask) is nonzero. addr, masks, and wdata are captured into that side's pending latch on that edge.
- Each side holds at most one pending-or-in-flight request. A second request from the same side before its resp is illegal, and the bench asserts on it.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - Any pending request → issue it, go to BUSY_x.
  - If both are pending, DMEM_PRIORITY picks the winner.
- Issue means:
  - Load mem_* flops from the winner's latch on the transition edge.
  - The mem masks are nonzero for exactly one cycle, then zero. mem_addr and mem_wdata hold until the next issue.
- BUSY_x with mem_resp:
  - Pulse x_resp combinationally with mem_rdata passed through, and clear x's pending.
  - If the other side is pending, issue it on the same edge and go to BUSY_other. Otherwise go to IDLE.
- BUSY_x without mem_resp: hold.
- A new request from side x in the same cycle as x_resp is legal. It is captured into a fresh pending entry, and the in-flight one is retired.
- A request arriving in the same cycle as the edge that issues from an empty latch is captured. It is considered on the next decision.
- mem_resp in IDLE is ignored and produces no *_resp.
- Arbitration is evaluated only at IDLE or at a completion. There is no preemption.

## Timing
- Reset values:
  - state = IDLE; both pending = 0.
  - mem_addr, mem_wdata = 0; mem_rmask, mem_wmask = 0.
  - imem_resp = dmem_resp = 0; imem_rdata, dmem_rdata = 0 while no resp.
- Request at edge T (idle, no contention) → mem mask pulse in cycle T+1.
- mem_resp in cycle R → x_resp in cycle R (zero added latency).
- Best-case round trip is mem latency + 1 cycle.
- Back-to-back: completion in cycle R and the other side pending → next mem mask pulse in cycle R+1. There are no idle bubbles.
- rst mid-transaction:
  - Everything returns to reset values immediately.
  - The outstanding memory response is dropped.
  - No *_resp is emitted for requests accepted before reset.
- *_resp are never high simultaneously. At most one mem request is outstanding.

## Structure
- Shared package rv32i_types holds:
  - mem_arb_state_t (IDLE, BUSY_I, BUSY_D)
  - mem_req_t struct (addr[31:0], rmask[3:0], wmask[3:0], wdata[31:0], valid)
- One sub-module, mem_req_latch, instantiated twice (imem, dmem):
  - Inputs: capture on nonzero mask, clear on retire.
  - Output: mem_req_t.
  - If capture and clear occur in the same cycle, capture wins.
- The top level holds the FSM, issue flops, and response demux.

## Test plan
- Lone fetch: imem_addr=0x6000_0000, rmask=4'hF at T; memory resp 2 cycles after the mask pulse with rdata=0x0000_0013 → mem_rmask=F only in T+1, imem_resp and imem_rdata=0x13 in T+3, dmem_resp stays 0.
- Simultaneous requests, DMEM_PRIORITY=1: fetch 0x6000_0004 and store 0x6000_1000 with wmask=4'h3, wdata=0xDEAD_BEEF at the same edge → store issued first with those values; fetch mask pulse in the cycle after the store's mem_resp.
- Same-cycle re-request: a new imem request 0x6000_0008 arrives in the imem_resp cycle → issued next cycle with no lost request, and exactly one imem_resp per request.
- Stray response: mem_resp=1, mem_rdata=0x1234 while IDLE → no *_resp, state stays IDLE.
- Async reset mid-flight: rst asserted between a dmem load issue and its mem_resp → outputs at reset values before the next clk edge, and the later mem_resp yields no dmem_resp.
- Random stress: 10k cycles, random mem latency 1–8 and legal requests on both sides → response count matches request count per side, rdata matches the reference memory, and no overlapping mem masks.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types for the memory arbiter: FSM state encoding and the pending-request record.
package rv32i_types;

   typedef enum logic [1:0] {
      IDLE,
      BUSY_I,
      BUSY_D
   } mem_arb_state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  rmask;
      logic [3:0]  wmask;
      logic [31:0] wdata;
      logic        valid;
   } mem_req_t;

endpackage

// File: rtl/mem_req_latch.sv
// One-deep pending-request holder for a single requester; captures on a nonzero mask.
module mem_req_latch
   import rv32i_types::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [3:0]  rmask,
   input  logic [3:0]  wmask,
   input  logic [31:0] wdata,
   input  logic        clear,
   output mem_req_t    req
);

   mem_req_t req_q, req_d;
   logic     capture;

   assign capture = |{rmask, wmask};

   // A fresh request in the retire cycle must survive, so capture overrides clear.
   always_comb begin
      req_d = req_q;
      if (clear) begin
         req_d.valid = 1'b0;
      end
      if (capture) begin
         req_d.addr  = addr;
         req_d.rmask = rmask;
         req_d.wmask = wmask;
         req_d.wdata = wdata;
         req_d.valid = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_q <= '0;
      end else begin
         req_q <= req_d;
      end
   end

   assign req = req_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates imem fetches and dmem loads/stores onto one memory port, one request in flight.
module mem_arbiter
   import rv32i_types::*;
#(
   parameter bit DMEM_PRIORITY = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] imem_addr,
   input  logic [3:0]  imem_rmask,
   output logic [31:0] imem_rdata,
   output logic        imem_resp,
   input  logic [31:0] dmem_addr,
   input  logic [3:0]  dmem_rmask,
   input  logic [3:0]  dmem_wmask,
   input  logic [31:0] dmem_wdata,
   output logic [31:0] dmem_rdata,
   output logic        dmem_resp,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_rmask,
   output logic [3:0]  mem_wmask,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_resp
);

   mem_arb_state_t state_q, state_d;
   mem_req_t       imem_req, dmem_req;
   logic           imem_clear, dmem_clear;
   logic           issue_i, issue_d, issue;

   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]  mem_rmask_q, mem_rmask_d;
   logic [3:0]  mem_wmask_q, mem_wmask_d;

   mem_req_latch u_imem_latch (
      .clk   (clk),
      .rst   (rst),
      .addr  (imem_addr),
      .rmask (imem_rmask),
      .wmask (4'h0),
      .wdata (32'h0),
      .clear (imem_clear),
      .req   (imem_req)
   );

   mem_req_latch u_dmem_latch (
      .clk   (clk),
      .rst   (rst),
      .addr  (dmem_addr),
      .rmask (dmem_rmask),
      .wmask (dmem_wmask),
      .wdata (dmem_wdata),
      .clear (dmem_clear),
      .req   (dmem_req)
   );

   // The in-flight side's latch stays valid until its completion, so on a completion only
   // the other side is a candidate for the next issue.
   always_comb begin
      state_d    = state_q;
      issue_i    = 1'b0;
      issue_d    = 1'b0;
      imem_clear = 1'b0;
      dmem_clear = 1'b0;
      imem_resp  = 1'b0;
      dmem_resp  = 1'b0;
      imem_rdata = 32'h0;
      dmem_rdata = 32'h0;
      unique case (state_q)
         IDLE: begin
            if (imem_req.valid && dmem_req.valid) begin
               issue_d = DMEM_PRIORITY;
               issue_i = !DMEM_PRIORITY;
            end else begin
               issue_i = imem_req.valid;
               issue_d = dmem_req.valid;
            end
         end
         BUSY_I: begin
            if (mem_resp) begin
               imem_resp  = 1'b1;
               imem_rdata = mem_rdata;
               imem_clear = 1'b1;
               issue_d    = dmem_req.valid;
               state_d    = IDLE;
            end
         end
         BUSY_D: begin
            if (mem_resp) begin
               dmem_resp  = 1'b1;
               dmem_rdata = mem_rdata;
               dmem_clear = 1'b1;
               issue_i    = imem_req.valid;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (issue_i) begin
         state_d = BUSY_I;
      end
      if (issue_d) begin
         state_d = BUSY_D;
      end
   end

   assign issue = issue_i | issue_d;

   // Address and write data hold between issues; masks are single-cycle pulses.
   always_comb begin
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_rmask_d = 4'h0;
      mem_wmask_d = 4'h0;
      if (issue) begin
         mem_addr_d  = issue_d ? dmem_req.addr  : imem_req.addr;
         mem_wdata_d = issue_d ? dmem_req.wdata : imem_req.wdata;
         mem_rmask_d = issue_d ? dmem_req.rmask : imem_req.rmask;
         mem_wmask_d = issue_d ? dmem_req.wmask : imem_req.wmask;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
         mem_rmask_q <= 4'h0;
         mem_wmask_q <= 4'h0;
      end else begin
         state_q     <= state_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_rmask_q <= mem_rmask_d;
         mem_wmask_q <= mem_wmask_d;
      end
   end

   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_rmask = mem_rmask_q;
   assign mem_wmask = mem_wmask_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and random-stress bench for mem_arbiter against a latency-programmable memory model.
module tb_mem_arbiter;
   import rv32i_types::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] imem_addr = '0;
   logic [3:0]  imem_rmask = '0;
   logic [31:0] imem_rdata;
   logic        imem_resp;
   logic [31:0] dmem_addr = '0;
   logic [3:0]  dmem_rmask = '0;
   logic [3:0]  dmem_wmask = '0;
   logic [31:0] dmem_wdata = '0;
   logic [31:0] dmem_rdata;
   logic        dmem_resp;
   logic [31:0] mem_addr;
   logic [3:0]  mem_rmask;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_resp;

   int n_checks = 0;
   int n_errors = 0;

   // Memory model state; model response ORed with a directly driven stray response.
   logic        m_resp = 1'b0;
   logic [31:0] m_rdata = '0;
   logic        s_resp = 1'b0;
   logic [31:0] s_rdata = '0;
   int unsigned cnt = 0;
   int unsigned lat = 2;
   bit          rand_lat = 1'b0;
   bit          use_fixed = 1'b1;
   logic [31:0] fixed_rdata = '0;
   logic [31:0] pend_addr = '0;
   bit          pend_rd = 1'b0;
   bit          prev_pulse = 1'b0;
   int          i_resp_cnt = 0;

   assign mem_resp  = m_resp | s_resp;
   assign mem_rdata = m_resp ? m_rdata : s_rdata;

   always #5 clk = ~clk;

   mem_arbiter #(
      .DMEM_PRIORITY (1'b1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .imem_addr  (imem_addr),
      .imem_rmask (imem_rmask),
      .imem_rdata (imem_rdata),
      .imem_resp  (imem_resp),
      .dmem_addr  (dmem_addr),
      .dmem_rmask (dmem_rmask),
      .dmem_wmask (dmem_wmask),
      .dmem_wdata (dmem_wdata),
      .dmem_rdata (dmem_rdata),
      .dmem_resp  (dmem_resp),
      .mem_addr   (mem_addr),
      .mem_rmask  (mem_rmask),
      .mem_wmask  (mem_wmask),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_resp   (mem_resp)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_data(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_3C3C;
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Memory: response lat cycles after the mask pulse; flags overlapping or stretched pulses.
   always begin
      @(posedge clk);
      #1;
      m_resp  = 1'b0;
      m_rdata = '0;
      if (cnt != 0) begin
         cnt--;
         if (cnt == 0) begin
            m_resp  = 1'b1;
            m_rdata = !pend_rd ? 32'h0 : (use_fixed ? fixed_rdata : ref_data(pend_addr));
         end
      end
      if (mem_rmask != 4'h0 || mem_wmask != 4'h0) begin
         check("mem_overlap", {31'b0, (cnt != 0) || prev_pulse}, 32'h0);
         pend_addr  = mem_addr;
         pend_rd    = (mem_rmask != 4'h0);
         cnt        = rand_lat ? $urandom_range(1, 8) : lat;
         prev_pulse = 1'b1;
      end else begin
         prev_pulse = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (imem_resp) i_resp_cnt++;
   end

   initial begin
      int          i_req, i_rsp, d_req, d_rsp, base;
      bit          i_out, d_out;
      logic [31:0] i_exp, d_exp;
      i_req = 0; i_rsp = 0; d_req = 0; d_rsp = 0;
      i_out = 1'b0; d_out = 1'b0;
      i_exp = '0; d_exp = '0;

      // Reset values
      #3;
      check("rst_state", 32'(dut.state_q), 32'(IDLE));
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_rmask", mem_rmask, 32'h0);
      check("rst_mem_wmask", mem_wmask, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      check("rst_resp", {imem_resp, dmem_resp}, 32'h0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Lone fetch, memory latency 2
      lat = 2;
      fixed_rdata = 32'h0000_0013;
      imem_addr  = 32'h6000_0000;
      imem_rmask = 4'hF;
      tick();
      imem_rmask = 4'h0;
      check("t1_no_early_issue", mem_rmask, 32'h0);
      tick();
      check("t1_rmask_pulse", mem_rmask, 32'hF);
      check("t1_addr", mem_addr, 32'h6000_0000);
      tick();
      check("t1_rmask_drop", mem_rmask, 32'h0);
      check("t1_no_early_resp", imem_resp, 32'h0);
      tick();
      check("t1_imem_resp", imem_resp, 32'h1);
      check("t1_imem_rdata", imem_rdata, 32'h0000_0013);
      check("t1_dmem_quiet", dmem_resp, 32'h0);
      tick();
      check("t1_resp_pulse", imem_resp, 32'h0);
      check("t1_rdata_idle", imem_rdata, 32'h0);

      // Simultaneous fetch and store: dmem wins
      fixed_rdata = 32'h0000_0093;
      imem_addr  = 32'h6000_0004;
      imem_rmask = 4'hF;
      dmem_addr  = 32'h6000_1000;
      dmem_wmask = 4'h3;
      dmem_wdata = 32'hDEAD_BEEF;
      tick();
      imem_rmask = 4'h0;
      dmem_wmask = 4'h0;
      tick();
      check("t2_wmask", mem_wmask, 32'h3);
      check("t2_rmask_hold", mem_rmask, 32'h0);
      check("t2_addr", mem_addr, 32'h6000_1000);
      check("t2_wdata", mem_wdata, 32'hDEAD_BEEF);
      tick();
      check("t2_wmask_drop", mem_wmask, 32'h0);
      tick();
      check("t2_dmem_resp", dmem_resp, 32'h1);
      check("t2_imem_quiet", imem_resp, 32'h0);
      tick();
      check("t2_fetch_pulse", mem_rmask, 32'hF);
      check("t2_fetch_addr", mem_addr, 32'h6000_0004);
      check("t2_dmem_resp_drop", dmem_resp, 32'h0);
      tick();
      tick();
      check("t2_imem_resp", imem_resp, 32'h1);
      check("t2_imem_rdata", imem_rdata, 32'h0000_0093);
      tick();

      // Re-request in the imem_resp cycle, memory latency 1
      lat = 1;
      base = i_resp_cnt;
      fixed_rdata = 32'h0000_0113;
      imem_addr  = 32'h6000_0010;
      imem_rmask = 4'hF;
      tick();
      imem_rmask = 4'h0;
      tick();
      check("t3_first_pulse", mem_rmask, 32'hF);
      tick();
      check("t3_first_resp", imem_resp, 32'h1);
      check("t3_first_rdata", imem_rdata, 32'h0000_0113);
      imem_addr  = 32'h6000_0008;
      imem_rmask = 4'hF;
      fixed_rdata = 32'h0000_0213;
      tick();
      imem_rmask = 4'h0;
      check("t3_resp_single", imem_resp, 32'h0);
      tick();
      check("t3_second_pulse", mem_rmask, 32'hF);
      check("t3_second_addr", mem_addr, 32'h6000_0008);
      tick();
      check("t3_second_resp", imem_resp, 32'h1);
      check("t3_second_rdata", imem_rdata, 32'h0000_0213);
      tick();
      check("t3_no_reissue", mem_rmask, 32'h0);
      check("t3_resp_count", i_resp_cnt - base, 32'd2);

      // Stray response while idle
      tick();
      s_resp  = 1'b1;
      s_rdata = 32'h0000_1234;
      #1;
      check("t4_no_resp", {imem_resp, dmem_resp}, 32'h0);
      check("t4_rdata_zero", imem_rdata | dmem_rdata, 32'h0);
      tick();
      s_resp  = 1'b0;
      s_rdata = '0;
      check("t4_state_idle", 32'(dut.state_q), 32'(IDLE));
      check("t4_no_issue", {mem_rmask, mem_wmask}, 32'h0);

      // Asynchronous reset between a load issue and its response
      lat = 3;
      fixed_rdata = 32'hCAFE_0001;
      dmem_addr  = 32'h6000_2000;
      dmem_rmask = 4'hF;
      tick();
      dmem_rmask = 4'h0;
      tick();
      check("t5_load_pulse", mem_rmask, 32'hF);
      check("t5_load_addr", mem_addr, 32'h6000_2000);
      tick();
      rst = 1'b1;
      #1;
      check("t5_rst_addr", mem_addr, 32'h0);
      check("t5_rst_wdata", mem_wdata, 32'h0);
      check("t5_rst_state", 32'(dut.state_q), 32'(IDLE));
      tick();
      rst = 1'b0;
      tick();
      check("t5_dropped_resp", dmem_resp, 32'h0);
      check("t5_dropped_rdata", dmem_rdata, 32'h0);
      check("t5_no_reissue_a", mem_rmask, 32'h0);
      tick();
      check("t5_no_reissue_b", {mem_rmask, mem_wmask}, 32'h0);
      tick();

      // Random stress with legal traffic on both sides
      use_fixed = 1'b0;
      rand_lat  = 1'b1;
      for (int cyc = 0; cyc < 10200; cyc++) begin
         tick();
         imem_rmask = 4'h0;
         dmem_rmask = 4'h0;
         dmem_wmask = 4'h0;
         if (imem_resp || dmem_resp) begin
            check("s_both_resp", {31'b0, imem_resp & dmem_resp}, 32'h0);
         end
         if (imem_resp) begin
            check("s_i_owner", {31'b0, i_out}, 32'h1);
            check("s_i_rdata", imem_rdata, i_exp);
            i_out = 1'b0;
            i_rsp++;
         end
         if (dmem_resp) begin
            check("s_d_owner", {31'b0, d_out}, 32'h1);
            check("s_d_rdata", dmem_rdata, d_exp);
            d_out = 1'b0;
            d_rsp++;
         end
         if (cyc < 10000) begin
            if (!i_out && $urandom_range(0, 2) == 0) begin
               imem_addr  = $urandom() & 32'hFFFF_FFFC;
               imem_rmask = 4'hF;
               i_exp = ref_data(imem_addr);
               i_out = 1'b1;
               i_req++;
            end
            if (!d_out && $urandom_range(0, 2) == 0) begin
               dmem_addr = $urandom();
               if ($urandom_range(0, 1) == 1) begin
                  dmem_wmask = 4'($urandom_range(1, 15));
                  dmem_wdata = $urandom();
                  d_exp = 32'h0;
               end else begin
                  dmem_rmask = 4'($urandom_range(1, 15));
                  d_exp = ref_data(dmem_addr);
               end
               d_out = 1'b1;
               d_req++;
            end
         end
      end
      check("s_drain_i", {31'b0, i_out}, 32'h0);
      check("s_drain_d", {31'b0, d_out}, 32'h0);
      check("s_count_i", i_rsp, i_req);
      check("s_count_d", d_rsp, d_req);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
